fir_mac_sequencer: RTL and testbench
====================================

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 The block SHALL have the port in_data  input  16  signed input sample.
REQ-003 The block SHALL have the port in_valid  input  1  sample offered.
REQ-004 The block SHALL have the port in_ready  output  1  block can accept a sample.
REQ-005 The block SHALL have the port out_data  output  16  signed filtered result.
REQ-006 The block SHALL have the port out_valid  output  1  out_data valid.
REQ-007 The block SHALL have the port out_ready  input  1  consumer accepts result.
REQ-008 The block SHALL have the port coef_we  input  1  coefficient write strobe.
REQ-009 The block SHALL have the port coef_addr  input  4  coefficient index, 0..9.
REQ-010 The block SHALL have the port coef_data  input  16  signed coefficient value.
REQ-011 The block SHALL have the port busy  output  1  high in MAC or OUT state.

Function
REQ-012 The block SHALL implement a 20-tap symmetric FIR using one shared pre-adder and multiplier; h[k] = h[19-k] = c[k] for k = 0..9.
REQ-013 The delay line SHALL be a 20-entry circular buffer with a write pointer that advances on each accepted sample and wraps from 19 to 0.
REQ-014 The FSM SHALL have three states: IDLE (in_ready=1), MAC (10 cycles, pair index k = 0..9) and OUT (out_valid=1).
REQ-015 An accepted sample (in_valid & in_ready at edge E0) SHALL be written to the delay line, clear the accumulator and move the FSM from IDLE to MAC.
REQ-016 At each of edges E1..E10 the block SHALL accumulate acc += (x[n-k] + x[n-19+k]) * c[k], for k = 0..9, where x[n] is the newest sample.
REQ-017 At edge E10 the FSM SHALL move to OUT, so out_valid is first visible in the cycle after E10.
REQ-018 Width rules: pre-add 17-bit signed; product 33-bit signed; accumulator 38-bit signed, which SHALL never overflow.
REQ-019 out_data SHALL be acc arithmetically shifted right by 12, truncated to its low 16 bits (wraps, no saturation); it SHALL be registered and held stable throughout OUT.
REQ-020 In OUT, the FSM SHALL move to IDLE on the edge where out_ready=1; while out_ready=0 it SHALL remain in OUT with out_data unchanged.
REQ-021 Minimum sample period SHALL be 12 cycles (1 IDLE + 10 MAC + 1 OUT, with out_ready held high).
REQ-022 in_valid while not in IDLE SHALL be ignored; the sample is not stored and the upstream must hold it.
REQ-023 A coef_we in IDLE with coef_addr <= 9 SHALL update c[coef_addr] at that edge.
REQ-024 A coef_we with coef_addr >= 10, or while busy=1, SHALL be ignored.
REQ-025 A coefficient write and a sample accept at the same IDLE edge SHALL both take effect, and the MAC for that sample SHALL use the new coefficient.
REQ-026 Until the delay line has received 20 samples, unfilled entries SHALL read as zero.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL clear all 20 delay entries, write pointer, accumulator, k and out_data to 0; deassert out_valid; and enter IDLE (in_ready=1 and busy=0 in the following cycle).
REQ-028 On reset, coefficients SHALL load defaults c[0..9] = 16'hFFEB, 0008, 0022, 004F, 008F, 00DC, 012E, 017A, 01B5, 01D5.
REQ-029 Reset asserted mid-MAC or in OUT SHALL abort the computation with no out_valid produced, and reset SHALL take priority over every simultaneous input.

Verification
REQ-030 Impulse test: after reset, feed 16'h1000 then 20 zeros with out_ready=1 -> outputs -21, 8, 34, 79, 143, 220, 302, 378, 437, 469, 469, 437, 378, 302, 220, 143, 79, 34, 8, -21, then 0.
REQ-031 DC test: feed 25 samples of 4096 -> outputs ramp up and reach 4098 from the 20th sample onward.
REQ-032 Latency and backpressure test: accept at E0 -> out_valid in the cycle after E10; hold out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0, and an offered sample is not consumed.
REQ-033 Coefficient test: a write to addr 9 = 0 while busy is ignored (impulse still yields 469); the same write in IDLE yields 0 at output positions 10 and 11; a write to addr 12 changes nothing.
REQ-034 Reset test: assert rst at E5 of a MAC -> no out_valid; in_ready=1 the cycle after reset; the next impulse response matches REQ-030 with default coefficients.
REQ-035 Wrap-around test: feed 45 random samples with random out_ready stalls -> every output matches a 20-tap golden model bit-exactly, including across pointer wraps.

Source files
------------

// File: rtl/fir_mac_sequencer_if.sv
// rtl/fir_mac_sequencer_if.sv - sample, result and coefficient port bundle for fir_mac_sequencer
interface fir_mac_sequencer_if;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               coef_we;
    logic [3:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic               busy;

    modport slave (
        input  in_data, in_valid, out_ready, coef_we, coef_addr, coef_data,
        output in_ready, out_data, out_valid, busy
    );

    modport master (
        output in_data, in_valid, out_ready, coef_we, coef_addr, coef_data,
        input  in_ready, out_data, out_valid, busy
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - 20-tap symmetric FIR, one shared pre-adder/multiplier over 10 MAC cycles
module fir_mac_sequencer (
    input  logic              clk,
    input  logic              rst,
    fir_mac_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    function automatic logic signed [15:0] coef_default(input int idx);
        case (idx)
            0:       return 16'hFFEB;
            1:       return 16'h0008;
            2:       return 16'h0022;
            3:       return 16'h004F;
            4:       return 16'h008F;
            5:       return 16'h00DC;
            6:       return 16'h012E;
            7:       return 16'h017A;
            8:       return 16'h01B5;
            default: return 16'h01D5;
        endcase
    endfunction

    state_t             state_q;
    logic signed [15:0] dl_q [20];
    logic signed [15:0] coef_q [10];
    logic [4:0]         wptr_q;
    logic [3:0]         k_q;
    logic signed [37:0] acc_q;
    logic signed [15:0] out_data_q;
    logic               out_valid_q;
    logic               in_ready_q;
    logic               busy_q;

    logic [4:0]         rd_a;
    logic [4:0]         rd_b;
    logic [4:0]         sum_b;
    logic signed [16:0] pre_add;
    logic signed [32:0] product;
    logic signed [37:0] acc_d;

    // wptr_q already points past the newest sample, so x[n-k] sits at wptr-1-k
    // and its partner x[n-19+k] sits at wptr+k, both modulo 20.
    always_comb begin
        rd_a    = (wptr_q > {1'b0, k_q}) ? (wptr_q - 5'd1 - {1'b0, k_q})
                                         : (wptr_q + 5'd19 - {1'b0, k_q});
        sum_b   = wptr_q + {1'b0, k_q};
        rd_b    = (sum_b >= 5'd20) ? (sum_b - 5'd20) : sum_b;
        pre_add = $signed({dl_q[rd_a][15], dl_q[rd_a]}) + $signed({dl_q[rd_b][15], dl_q[rd_b]});
        product = $signed({{16{pre_add[16]}}, pre_add}) * $signed({{17{coef_q[k_q][15]}}, coef_q[k_q]});
        acc_d   = acc_q + $signed({{5{product[32]}}, product});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < 20; i++) dl_q[i] <= '0;
            for (int i = 0; i < 10; i++) coef_q[i] <= coef_default(i);
            wptr_q      <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.coef_we && bus.coef_addr <= 4'd9)
                        coef_q[bus.coef_addr] <= bus.coef_data;
                    if (bus.in_valid) begin
                        dl_q[wptr_q] <= bus.in_data;
                        wptr_q       <= (wptr_q == 5'd19) ? 5'd0 : wptr_q + 5'd1;
                        acc_q        <= '0;
                        k_q          <= '0;
                        state_q      <= MAC;
                        in_ready_q   <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + 4'd1;
                    if (k_q == 4'd9) begin
                        state_q     <= OUT;
                        out_valid_q <= 1'b1;
                        out_data_q  <= acc_d[27:12];
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - randomized and directed bench for fir_mac_sequencer
module tb_fir_mac_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fir_mac_sequencer_if bus ();
    fir_mac_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit armed   = 1'b0;
    bit rand_mode = 1'b0;

    // Reference: full 20-tap convolution over every accepted sample, plus a
    // cycle count since acceptance for the handshake timing.
    int                 phase;
    logic signed [15:0] mc [10];
    logic signed [15:0] hist [$];
    longint             expq [$];
    logic signed [15:0] got_q [$];

    localparam int IMP [21] = '{-21, 8, 34, 79, 143, 220, 302, 378, 437, 469,
                                469, 437, 378, 302, 220, 143, 79, 34, 8, -21, 0};

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        phase = 0;
        hist.delete();
        expq.delete();
        mc[0] = -16'sd21; mc[1] = 16'sd8;   mc[2] = 16'sd34;  mc[3] = 16'sd79;  mc[4] = 16'sd143;
        mc[5] = 16'sd220; mc[6] = 16'sd302; mc[7] = 16'sd378; mc[8] = 16'sd437; mc[9] = 16'sd469;
    endtask

    function automatic longint model_out();
        longint acc = 0;
        int n = hist.size();
        for (int t = 0; t < 20; t++)
            if (t < n) acc += longint'(hist[n-1-t]) * longint'(mc[(t < 10) ? t : 19 - t]);
        acc = acc >>> 12;
        return longint'($signed(acc[15:0]));
    endfunction

    always @(negedge clk) begin
        if (!armed) begin
            if (rst) begin
                armed = 1'b1;
                model_reset();
            end
        end else begin
            chk("in_ready",  longint'(bus.in_ready),  longint'(phase == 0));
            chk("busy",      longint'(bus.busy),      longint'(phase != 0));
            chk("out_valid", longint'(bus.out_valid), longint'(phase == 11));
            if (phase == 11)
                chk("out_data", longint'(bus.out_data), (expq.size() > 0) ? expq[0] : 64'sd99999);
            if (rst) begin
                model_reset();
            end else if (phase == 0) begin
                if (bus.coef_we && bus.coef_addr <= 4'd9) mc[bus.coef_addr] = bus.coef_data;
                if (bus.in_valid) begin
                    hist.push_back(bus.in_data);
                    expq.push_back(model_out());
                    phase = 1;
                end
            end else if (phase <= 10) begin
                phase++;
            end else if (bus.out_ready) begin
                got_q.push_back(bus.out_data);
                if (expq.size() > 0) void'(expq.pop_front());
                phase = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_mode) bus.out_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        got_q.delete();
    endtask

    task automatic send(input logic [15:0] x, input bit we, input logic [3:0] a, input logic [15:0] d);
        bit ok = 1'b0;
        bus.in_data = x; bus.in_valid = 1'b1;
        bus.coef_we = we; bus.coef_addr = a; bus.coef_data = d;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1'b1; break; end
            step();
        end
        step();
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic coef_write(input logic [3:0] a, input logic [15:0] d);
        bus.coef_we = 1'b1; bus.coef_addr = a; bus.coef_data = d;
        step();
        bus.coef_we = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (expq.size() == 0) break;
            step();
        end
        chk("drain", expq.size(), 0);
    endtask

    function automatic longint got(input int i);
        return (i < got_q.size()) ? longint'(got_q[i]) : 64'sd99999;
    endfunction

    task automatic impulse_run(input string tag);
        send(16'h1000, 1'b0, 4'd0, 16'h0);
        for (int i = 0; i < 20; i++) send(16'h0000, 1'b0, 4'd0, 16'h0);
        drain();
        chk({tag, "_count"}, got_q.size(), 21);
        for (int i = 0; i < 21; i++) chk($sformatf("%s_%0d", tag, i), got(i), IMP[i]);
    endtask

    initial begin
        int lat;
        bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
        do_reset();

        impulse_run("impulse");

        do_reset();
        for (int i = 0; i < 25; i++) send(16'd4096, 1'b0, 4'd0, 16'h0);
        drain();
        chk("dc_first", got(0), -21);
        for (int i = 19; i < 25; i++) chk($sformatf("dc_%0d", i), got(i), 4098);

        do_reset();
        bus.out_ready = 1'b0;
        send(16'h0800, 1'b0, 4'd0, 16'h0);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
        end
        chk("latency", lat, 11);
        bus.in_data = 16'h1234; bus.in_valid = 1'b1;
        repeat (5) step();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        drain();
        send(16'h0000, 1'b0, 4'd0, 16'h0);
        drain();
        chk("bp_count", got_q.size(), 2);
        chk("bp_out0", got(0), -11);
        chk("bp_out1", got(1), 4);

        do_reset();
        send(16'h1000, 1'b0, 4'd0, 16'h0);
        repeat (3) step();
        coef_write(4'd9, 16'h0000);
        for (int i = 0; i < 19; i++) send(16'h0000, 1'b0, 4'd0, 16'h0);
        drain();
        chk("busy_wr_9",  got(9),  469);
        chk("busy_wr_10", got(10), 469);

        do_reset();
        coef_write(4'd12, 16'h7FFF);
        send(16'h1000, 1'b1, 4'd9, 16'h0000);
        for (int i = 0; i < 20; i++) send(16'h0000, 1'b0, 4'd0, 16'h0);
        drain();
        chk("idle_wr_0",  got(0),  -21);
        chk("idle_wr_4",  got(4),  143);
        chk("idle_wr_8",  got(8),  437);
        chk("idle_wr_9",  got(9),  0);
        chk("idle_wr_10", got(10), 0);
        chk("idle_wr_11", got(11), 437);
        chk("idle_wr_15", got(15), 143);

        do_reset();
        send(16'h1000, 1'b0, 4'd0, 16'h0);
        repeat (4) step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("abort_no_out", got_q.size(), 0);
        got_q.delete();
        impulse_run("post_reset");

        do_reset();
        rand_mode = 1'b1;
        for (int i = 0; i < 45; i++) begin
            repeat ($urandom_range(0, 3)) step();
            send(16'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 16'($urandom));
        end
        drain();
        rand_mode = 1'b0;
        bus.out_ready = 1'b1;
        chk("rand_count", got_q.size(), 45);

        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
